// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: assembles big-endian words from a byte
// stream and writes them to consecutive word addresses while holding the CPU.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] LP_CAP = {1'b1, {ADDR_W{1'b0}}};

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_word_idx;
    logic [1:0]        r_byte_idx;
    logic [31:0]       r_word;
    logic              r_err;

    logic              w_start_seen;
    logic              w_start_big;
    logic              w_start_zero;
    logic              w_byte_acc;
    logic              w_last_byte;
    logic [ADDR_W:0]   w_word_idx_inc;
    logic              w_last_word;

    assign w_start_seen   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_start_big    = (word_count > LP_CAP);
    assign w_start_zero   = (word_count == '0);
    assign w_byte_acc     = (r_state == S_RECV) && byte_valid;
    assign w_last_byte    = w_byte_acc && (r_byte_idx == 2'd3);
    assign w_word_idx_inc = r_word_idx + {{ADDR_W{1'b0}}, 1'b1};
    assign w_last_word    = (w_word_idx_inc == r_count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                // An oversize request always parks the loader in IDLE, even from DONE
                if (start) begin
                    if (w_start_big) begin
                        w_next = S_IDLE;
                    end else if (w_start_zero) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_RECV;
                    end
                end
            end
            S_RECV: begin
                if (w_last_byte) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_next = w_last_word ? S_DONE : S_RECV;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_word_idx <= '0;
            r_byte_idx <= 2'd0;
            r_word     <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            if (w_start_seen) begin
                r_err <= w_start_big;
                if (!w_start_big) begin
                    r_count    <= word_count;
                    r_word_idx <= '0;
                    r_byte_idx <= 2'd0;
                end
            end
            // Index wraps 3 -> 0 on the fourth byte, ready for the next word
            if (w_byte_acc) begin
                r_word     <= {r_word[23:0], byte_data};
                r_byte_idx <= r_byte_idx + 2'd1;
            end
            if (r_state == S_WRITE) begin
                r_word_idx <= w_word_idx_inc;
            end
        end
    end

    assign byte_ready = (r_state == S_RECV);
    assign mem_we     = (r_state == S_WRITE);
    assign mem_addr   = {{(32 - ADDR_W - 3){1'b0}}, r_word_idx, 2'b00};
    assign mem_wdata  = r_word;
    assign cpu_hold   = (r_state != S_DONE);
    assign done       = (r_state == S_DONE);
    assign err        = r_err;

endmodule
